// File: rtl/per_demux_pkg.sv
// Shared constants and the in-flight tracking entry for the peripheral address demux.
package per_demux_pkg;

    localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;
    localparam logic        OPC_OK    = 1'b0;
    localparam logic        OPC_ERR   = 1'b1;

    // Hits always index one of at most 16 targets, so 4 bits of index suffice for any IDX_WIDTH.
    localparam int unsigned IDX_STORE_W = 4;

    typedef struct packed {
        logic                   is_err;
        logic [IDX_STORE_W-1:0] idx;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/per_demux_idx_fifo.sv
// In-order tracking FIFO of granted requests; head is the entry owed the next response.
module per_demux_idx_fifo
    import per_demux_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] wr_entry,
    output logic [ENTRY_W-1:0] head,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_q, rd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = mem[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= next_ptr(wr_q);
            if (do_pop)  rd_q <= next_ptr(rd_q);
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/per_addr_demux.sv
// Routes bridge requests by address to NB_SLAVES targets and returns responses in issue order.
// Optional decode-error counter built when PER_DEMUX_ERR_CNT_EN is defined.
module per_addr_demux
    import per_demux_pkg::*;
#(
    parameter int unsigned NB_SLAVES       = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned IDX_LSB         = 10,
    parameter int unsigned IDX_WIDTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             per_slave_req_i,
    input  logic [ADDR_WIDTH-1:0]            per_slave_add_i,
    input  logic                             per_slave_wen_i,
    input  logic [DATA_WIDTH-1:0]            per_slave_wdata_i,
    input  logic [BE_WIDTH-1:0]              per_slave_be_i,
    output logic                             per_slave_gnt_o,
    output logic                             per_slave_r_valid_o,
    output logic                             per_slave_r_opc_o,
    output logic [DATA_WIDTH-1:0]            per_slave_r_rdata_o,
    output logic [NB_SLAVES-1:0]             per_master_req_o,
    output logic [NB_SLAVES*ADDR_WIDTH-1:0]  per_master_add_o,
    output logic [NB_SLAVES-1:0]             per_master_wen_o,
    output logic [NB_SLAVES*DATA_WIDTH-1:0]  per_master_wdata_o,
    output logic [NB_SLAVES*BE_WIDTH-1:0]    per_master_be_o,
    input  logic [NB_SLAVES-1:0]             per_master_gnt_i,
    input  logic [NB_SLAVES-1:0]             per_master_r_valid_i,
    input  logic [NB_SLAVES-1:0]             per_master_r_opc_i,
    input  logic [NB_SLAVES*DATA_WIDTH-1:0]  per_master_r_rdata_i,
    output logic                             busy_o,
    output logic [15:0]                      err_cnt_o
);

    localparam int unsigned           CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_RDATA);
    localparam logic [IDX_WIDTH:0]    NB_LIM   = (IDX_WIDTH + 1)'(NB_SLAVES);

    logic [IDX_WIDTH-1:0] idx;
    logic                 hit, full, empty, push, pop, err_q, err_d, stray_rvalid;
    logic [CNT_W-1:0]     count;
    logic [ENTRY_W-1:0]   head_raw;
    entry_t               push_e, head_e;
    logic [NB_SLAVES-1:0] sel, head_sel;

    assign idx    = per_slave_add_i[IDX_LSB +: IDX_WIDTH];
    assign hit    = ({1'b0, idx} < NB_LIM);
    assign head_e = entry_t'(head_raw);

    assign per_master_add_o   = {NB_SLAVES{per_slave_add_i}};
    assign per_master_wen_o   = {NB_SLAVES{per_slave_wen_i}};
    assign per_master_wdata_o = {NB_SLAVES{per_slave_wdata_i}};
    assign per_master_be_o    = {NB_SLAVES{per_slave_be_i}};

    always_comb begin
        sel      = '0;
        head_sel = '0;
        for (int unsigned i = 0; i < NB_SLAVES; i++) begin
            sel[i]      = hit && (idx == IDX_WIDTH'(i));
            head_sel[i] = !empty && !head_e.is_err && (head_e.idx == IDX_STORE_W'(i));
        end
    end

    // A full FIFO blocks every request, even if a response pops this very cycle.
    always_comb begin
        per_master_req_o = '0;
        per_slave_gnt_o  = 1'b0;
        if (!full) begin
            if (hit) begin
                per_master_req_o = sel & {NB_SLAVES{per_slave_req_i}};
                per_slave_gnt_o  = per_slave_req_i && |(sel & per_master_gnt_i);
            end else begin
                per_slave_gnt_o  = per_slave_req_i;
            end
        end
    end

    assign push          = per_slave_req_i && per_slave_gnt_o;
    assign push_e.is_err = !hit;
    assign push_e.idx    = IDX_STORE_W'(idx);

    always_comb begin
        per_slave_r_valid_o = 1'b0;
        per_slave_r_opc_o   = OPC_OK;
        per_slave_r_rdata_o = '0;
        if (err_q) begin
            per_slave_r_valid_o = 1'b1;
            per_slave_r_opc_o   = OPC_ERR;
            per_slave_r_rdata_o = ERR_DATA;
        end else begin
            for (int unsigned i = 0; i < NB_SLAVES; i++) begin
                if (head_sel[i]) begin
                    per_slave_r_valid_o = per_master_r_valid_i[i];
                    per_slave_r_opc_o   = per_master_r_opc_i[i];
                    per_slave_r_rdata_o = per_master_r_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign pop = per_slave_r_valid_o;

    // An error pushed into an empty FIFO is flagged at once, giving a one-cycle error response.
    always_comb begin
        err_d = 1'b0;
        if (!err_q) begin
            err_d = (!empty && head_e.is_err) || (empty && push && !hit);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign busy_o = (count != '0) || per_slave_req_i;

`ifdef PER_DEMUX_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else if (push && !hit && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

    per_demux_idx_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (push),
        .pop      (pop),
        .wr_entry (push_e),
        .head     (head_raw),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign stray_rvalid = !empty && |(per_master_r_valid_i & ~head_sel);

    a_no_stray_rvalid : assert property (@(posedge clk_i) disable iff (rst_i) !stray_rvalid)
        else $error("r_valid from a target that is not the response head");

endmodule

// File: tb/tb_per_addr_demux.sv
// Randomised and directed scoreboard bench for per_addr_demux.
module tb_per_addr_demux;

    localparam int NB = 4, AW = 32, DW = 32, BW = 4, ILSB = 10, IW = 4, MO = 4;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              per_slave_req_i = 1'b0;
    logic [AW-1:0]     per_slave_add_i = '0;
    logic              per_slave_wen_i = 1'b0;
    logic [DW-1:0]     per_slave_wdata_i = '0;
    logic [BW-1:0]     per_slave_be_i = '0;
    logic              per_slave_gnt_o, per_slave_r_valid_o, per_slave_r_opc_o;
    logic [DW-1:0]     per_slave_r_rdata_o;
    logic [NB-1:0]     per_master_req_o, per_master_wen_o;
    logic [NB*AW-1:0]  per_master_add_o;
    logic [NB*DW-1:0]  per_master_wdata_o;
    logic [NB*BW-1:0]  per_master_be_o;
    logic [NB-1:0]     per_master_gnt_i = '0, per_master_r_valid_i = '0, per_master_r_opc_i = '0;
    logic [NB*DW-1:0]  per_master_r_rdata_i = '0;
    logic              busy_o;
    logic [15:0]       err_cnt_o;

    always #5 clk_i = ~clk_i;

    per_addr_demux #(
        .NB_SLAVES(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
        .IDX_LSB(ILSB), .IDX_WIDTH(IW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .per_slave_req_i(per_slave_req_i), .per_slave_add_i(per_slave_add_i),
        .per_slave_wen_i(per_slave_wen_i), .per_slave_wdata_i(per_slave_wdata_i),
        .per_slave_be_i(per_slave_be_i), .per_slave_gnt_o(per_slave_gnt_o),
        .per_slave_r_valid_o(per_slave_r_valid_o), .per_slave_r_opc_o(per_slave_r_opc_o),
        .per_slave_r_rdata_o(per_slave_r_rdata_o), .per_master_req_o(per_master_req_o),
        .per_master_add_o(per_master_add_o), .per_master_wen_o(per_master_wen_o),
        .per_master_wdata_o(per_master_wdata_o), .per_master_be_o(per_master_be_o),
        .per_master_gnt_i(per_master_gnt_i), .per_master_r_valid_i(per_master_r_valid_i),
        .per_master_r_opc_i(per_master_r_opc_i), .per_master_r_rdata_i(per_master_r_rdata_i),
        .busy_o(busy_o), .err_cnt_o(err_cnt_o)
    );

    typedef struct {
        logic        opc;
        logic [31:0] rdata;
        int          gcyc;
        int          exp_lat;
    } exp_t;

    typedef struct {
        bit          is_err;
        int          tgt;
        int          ready;
        logic [31:0] rdata;
        logic        opc;
    } pend_t;

    exp_t  sb_q[$];
    pend_t env_q[$];

    int tests = 0, fails = 0, cyc = 0, err_model = 0;
    int gnt_pct = 100;
    logic [NB-1:0] hold = '0, stale_rv = '0;
    int cur_delay = 1, cur_lat = -1;
    logic [31:0] cur_rdata = '0;
    logic cur_opc = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Target models: only the target owed the oldest response ever drives r_valid.
    always @(posedge clk_i) begin
        int t;
        #2;
        for (int i = 0; i < NB; i++) begin
            per_master_gnt_i[i]             = ($urandom_range(99) < gnt_pct);
            per_master_r_opc_i[i]           = 1'($urandom_range(1));
            per_master_r_rdata_i[i*DW +: DW] = $urandom;
        end
        per_master_r_valid_i = stale_rv;
        if (env_q.size() != 0) begin
            t = env_q[0].tgt;
            if (!env_q[0].is_err && !hold[t] && cyc >= env_q[0].ready) begin
                per_master_r_valid_i[t]          = 1'b1;
                per_master_r_opc_i[t]            = env_q[0].opc;
                per_master_r_rdata_i[t*DW +: DW] = env_q[0].rdata;
            end
        end
    end

    // Request-phase model and scoreboard producer.
    always @(negedge clk_i) begin
        int idx;
        bit hit, full, ok;
        logic [NB-1:0] exp_req;
        logic exp_gnt;
        pend_t p;
        exp_t e;
        if (rst_i) begin
            env_q.delete();
            sb_q.delete();
            err_model = 0;
        end else begin
            full    = (env_q.size() >= MO);
            idx     = int'((per_slave_add_i >> ILSB) & ((1 << IW) - 1));
            hit     = (idx < NB);
            exp_req = '0;
            exp_gnt = 1'b0;
            if (per_slave_req_i && !full) begin
                if (hit) begin
                    exp_req = NB'(1 << idx);
                    exp_gnt = per_master_gnt_i[idx];
                end else begin
                    exp_gnt = 1'b1;
                end
            end
            check("target_req", 64'(per_master_req_o), 64'(exp_req));
            check("bridge_gnt", 64'(per_slave_gnt_o), 64'(exp_gnt));
            if (per_slave_req_i) begin
                ok = 1;
                for (int i = 0; i < NB; i++) begin
                    if (per_master_add_o[i*AW +: AW] !== per_slave_add_i ||
                        per_master_wen_o[i] !== per_slave_wen_i ||
                        per_master_wdata_o[i*DW +: DW] !== per_slave_wdata_i ||
                        per_master_be_o[i*BW +: BW] !== per_slave_be_i) ok = 0;
                end
                check("broadcast", 64'(ok), 64'd1);
            end
            if (per_slave_r_valid_o && env_q.size() != 0) void'(env_q.pop_front());
            if (per_slave_req_i && per_slave_gnt_o) begin
                p.is_err = !hit; p.tgt = idx; p.ready = cyc + cur_delay;
                p.rdata = cur_rdata; p.opc = cur_opc;
                env_q.push_back(p);
                e.opc     = hit ? cur_opc : 1'b1;
                e.rdata   = hit ? cur_rdata : 32'hBADACCE5;
                e.gcyc    = cyc;
                e.exp_lat = cur_lat;
                sb_q.push_back(e);
                if (!hit && err_model < 65535) err_model++;
            end
        end
    end

    // Monitor: consumes one expected response per DUT response.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i && per_slave_r_valid_o) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got r_valid with rdata %0h, required none (cycle %0d)",
                         per_slave_r_rdata_o, cyc);
            end else begin
                e = sb_q.pop_front();
                check("r_opc", 64'(per_slave_r_opc_o), 64'(e.opc));
                check("r_rdata", 64'(per_slave_r_rdata_o), 64'(e.rdata));
                if (e.exp_lat >= 0) check("rsp_latency", 64'(cyc - e.gcyc), 64'(e.exp_lat));
            end
        end
    end

    task automatic start_req(input logic [31:0] addr, input int delay, input int lat,
                             input logic opc);
        @(posedge clk_i);
        #1;
        per_slave_req_i   = 1'b1;
        per_slave_add_i   = addr;
        per_slave_wen_i   = 1'($urandom_range(1));
        per_slave_wdata_i = $urandom;
        per_slave_be_i    = BW'($urandom_range(15));
        cur_delay = delay;
        cur_lat   = lat;
        cur_rdata = $urandom;
        cur_opc   = opc;
    endtask

    task automatic wait_gnt();
        int n = 0;
        @(negedge clk_i);
        while (!per_slave_gnt_o && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        if (!per_slave_gnt_o) begin
            tests++;
            fails++;
            $display("FAIL gnt_timeout: got no grant in %0d cycles, required a grant", n);
        end
    endtask

    task automatic issue(input logic [31:0] addr, input int delay, input int lat);
        start_req(addr, delay, lat, 1'b0);
        wait_gnt();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
            per_slave_req_i = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while (env_q.size() != 0 && n < 2000) begin
            @(posedge clk_i);
            n++;
        end
        @(negedge clk_i);
        check("drain_done", 64'(env_q.size()), 64'd0);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        check("busy_idle", 64'(busy_o), 64'd0);
    endtask

    function automatic int exp_cnt();
`ifdef PER_DEMUX_ERR_CNT_EN
        return err_model;
`else
        return 0;
`endif
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int idx;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_gnt", 64'(per_slave_gnt_o), 64'd0);
        check("rst_rvalid", 64'(per_slave_r_valid_o), 64'd0);
        check("rst_ropc", 64'(per_slave_r_opc_o), 64'd0);
        check("rst_rdata", 64'(per_slave_r_rdata_o), 64'd0);
        check("rst_req", 64'(per_master_req_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_errcnt", 64'(err_cnt_o), 64'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Single read to target 2, response two cycles after grant.
        issue(32'h0000_0800, 2, 2);
        idle(4);

        // Target 0 is ready first but must wait behind target 1.
        issue(32'h0000_0400, 4, 4);
        issue(32'h0000_0000, 1, 4);
        idle(8);

        // Decode error: local response one cycle after grant.
        issue(32'h0000_1400, 1, 1);
        idle(3);
        @(negedge clk_i);
        check("err_cnt", 64'(err_cnt_o), 64'(exp_cnt()));

        // Fill the tracker with target 3 withholding; fifth request must stall.
        hold[3] = 1'b1;
        repeat (4) issue(32'h0000_0C00, 1, -1);
        start_req(32'h0000_0C00, 1, -1, 1'b0);
        repeat (3) begin
            @(negedge clk_i);
            check("full_gnt", 64'(per_slave_gnt_o), 64'd0);
            check("full_req", 64'(per_master_req_o), 64'd0);
        end
        hold[3] = 1'b0;
        wait_gnt();
        drain();

        // Reset with requests in flight; stale target responses must not leak.
        hold = '1;
        issue(32'h0000_0000, 1, -1);
        issue(32'h0000_0400, 1, -1);
        issue(32'h0000_0800, 1, -1);
        @(posedge clk_i);
        #1;
        per_slave_req_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("busy_after_rst", 64'(busy_o), 64'd0);
        hold = '0;
        stale_rv = 4'b0111;
        repeat (3) begin
            @(negedge clk_i);
            check("stale_rvalid", 64'(per_slave_r_valid_o), 64'd0);
        end
        stale_rv = '0;
        check("errcnt_after_rst", 64'(err_cnt_o), 64'd0);

        // Random mixed traffic.
        gnt_pct = 70;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            idx = $urandom_range(5);
            a[ILSB +: IW] = IW'(idx);
            start_req(a, $urandom_range(1, 4), -1, 1'($urandom_range(9) == 0));
            wait_gnt();
            idle($urandom_range(2));
        end
        drain();
        check("err_cnt_final", 64'(err_cnt_o), 64'(exp_cnt()));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/per_addr_demux.md
Name: per_addr_demux

Overview:
- Downstream stage of the cluster's AXI-to-peripheral bridge.
- Takes the single peripheral-bus master stream that the bridge produces (req/gnt request phase, r_valid/r_opc/r_rdata response phase) and routes each request, by address, to one of NB_SLAVES peripheral targets.
- Returns responses to the bridge in issue order and tracks up to MAX_OUTSTANDING in-flight requests.
- Addresses that decode to no target get a local error response.

Parameters:
- NB_SLAVES, 4: number of peripheral targets, 1..16; need not be a power of 2.
- ADDR_WIDTH, 32: request address width.
- DATA_WIDTH, 32: wdata/rdata width.
- BE_WIDTH, DATA_WIDTH/8: byte-enable width.
- IDX_LSB, 10: lowest address bit of the target-index field.
- IDX_WIDTH, 4: width of the target-index field, ≥ clog2(NB_SLAVES).
- MAX_OUTSTANDING, 4: depth of the in-order response-tracking FIFO, ≥ 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- per_slave_req_i  in  1  request from bridge.
- per_slave_add_i  in  ADDR_WIDTH  request address.
- per_slave_wen_i  in  1  1 = read, 0 = write.
- per_slave_wdata_i  in  DATA_WIDTH  write data.
- per_slave_be_i  in  BE_WIDTH  byte enables.
- per_slave_gnt_o  out  1  request accepted.
- per_slave_r_valid_o  out  1  response valid.
- per_slave_r_opc_o  out  1  0 = OK, 1 = error.
- per_slave_r_rdata_o  out  DATA_WIDTH  read data.
- per_master_req_o  out  NB_SLAVES  per-target request.
- per_master_add_o  out  NB_SLAVES×ADDR_WIDTH  address, broadcast.
- per_master_wen_o  out  NB_SLAVES  wen, broadcast.
- per_master_wdata_o  out  NB_SLAVES×DATA_WIDTH  wdata, broadcast.
- per_master_be_o  out  NB_SLAVES×BE_WIDTH  be, broadcast.
- per_master_gnt_i  in  NB_SLAVES  per-target grant.
- per_master_r_valid_i  in  NB_SLAVES  per-target response valid.
- per_master_r_opc_i  in  NB_SLAVES  per-target response error.
- per_master_r_rdata_i  in  NB_SLAVES×DATA_WIDTH  per-target read data.
- busy_o  out  1  at least one request outstanding.
- err_cnt_o  out  16  decode-error count (see Optional Feature).

Clock/reset (already decided): one clock, clk_i; reset rst_i is synchronous and active-high.

Behaviour:
- Decode: idx = per_slave_add_i[IDX_LSB +: IDX_WIDTH].
  - idx < NB_SLAVES: hit on target idx.
  - Otherwise: decode error (ERR).
- Request phase is combinational. For a hit with FIFO not full:
  - per_master_req_o[idx] = per_slave_req_i; all other req bits 0.
  - per_slave_gnt_o = per_master_gnt_i[idx].
- FIFO full: all per_master_req_o = 0 and per_slave_gnt_o = 0. A pop in the same cycle does not free a slot for that cycle.
- ERR request with FIFO not full: granted locally, per_slave_gnt_o = 1 in the same cycle.
- FIFO push: on each handshake (req & gnt), push {is_err, idx}.
- Response selection:
  - Head is a hit: per_slave_r_valid_o/r_opc_o/r_rdata_o = per_master_r_valid_i/r_opc_i/r_rdata_i of the head target.
  - FIFO pop: when per_slave_r_valid_o = 1.
- Error response: registered flag err_q.
  - err_q is set the cycle after an ERR entry becomes head.
  - While err_q = 1: per_slave_r_valid_o = 1, r_opc_o = 1, r_rdata_o = ERR_RDATA (32'hBADACCE5, zero-extended or truncated to DATA_WIDTH); entry pops; err_q clears.
  - Minimum ERR latency is 1 cycle after grant.
- Targets respond ≥ 1 cycle after grant, in order per target.
- r_valid from a target that is not the head target is ignored; it is a protocol violation covered by assertion.
- No valid head: r_valid_o = 0, r_opc_o = 0, r_rdata_o = 0.
- Simultaneous push and pop in one cycle: allowed when not full; occupancy is unchanged.
- Wrap: FIFO pointers wrap modulo MAX_OUTSTANDING; occupancy count is clog2(MAX_OUTSTANDING+1) bits.
- busy_o = (count != 0) | per_slave_req_i.
- Reset: FIFO emptied, err_q = 0, err_cnt_o = 0. Reset mid-operation discards outstanding entries; late target responses after reset are ignored.
- Reset values of all outputs:
  - Registered outputs reset to 0.
  - Combinational outputs are 0 whenever per_slave_req_i = 0 and the FIFO is empty.

Optional Feature:
- Macro PER_DEMUX_ERR_CNT_EN.
- Defined: err_cnt_o is a 16-bit counter, incremented on each granted ERR request, saturating at 16'hFFFF, cleared by rst_i.
- Undefined: err_cnt_o tied to 0 and no counter logic is built.

Decomposition:
- Package per_demux_pkg holds:
  - ERR_RDATA constant.
  - OPC_OK/OPC_ERR constants.
  - Typedef of the tracking entry {logic is_err; logic [IDX_WIDTH-1:0] idx}.
- Sub-module per_demux_idx_fifo: synchronous FIFO with push/pop/full/empty/count and head output, depth MAX_OUTSTANDING.
- The demux top holds decode, muxing and err_q.

Test Plan:
- Read to 0x0000_0800 (idx 2); target 2 grants at once and responds 2 cycles later with rdata 0x1234_5678 -> bridge sees gnt same cycle, r_valid 2 cycles after grant, rdata 0x1234_5678, r_opc 0; no req on targets 0, 1, 3.
- Back-to-back reads to idx 1 then idx 0; target 0 is ready before target 1 -> responses returned in issue order (idx 1 first); target 0 data is held until idx 1 pops.
- Access to 0x0000_1400 (idx 5, NB_SLAVES = 4) -> gnt same cycle, r_valid 1 cycle later with r_opc 1 and rdata 0xBADACCE5; err_cnt_o = 1 with the macro defined, 0 without.
- Issue 5 requests to idx 3 with target 3 withholding responses (MAX_OUTSTANDING = 4) -> first 4 granted; the 5th sees gnt 0 and per_master_req_o 0 until one response pops.
- Assert rst_i for 1 cycle with 3 requests outstanding -> busy_o 0 next cycle; subsequent stale target r_valid does not reach the bridge.
- Continuous traffic of 1000 random requests mixing hits and ERR -> every request gets exactly one response, in order, and busy_o ends at 0.
